// File: rtl/usb4_timer_pkg.sv
// Shared types and defaults for the USB4 sideband millisecond timeout timer.
package usb4_timer_pkg;

    typedef enum logic [0:0] {
        TMR_IDLE,
        TMR_RUN
    } tmr_state_e;

    localparam int unsigned CYCLES_PER_MS_DEF = 1000;
    localparam int unsigned TMR_W_DEF         = 10;

endpackage

// File: rtl/sb_ms_prescaler.sv
// Free-running sb_clk-to-millisecond prescaler; counts 0..CYCLES_PER_MS-1 while enabled.
module sb_ms_prescaler
    import usb4_timer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = CYCLES_PER_MS_DEF
) (
    input  logic sb_clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      CNT_W = $clog2(CYCLES_PER_MS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Wrap is due on the next enabled edge; the owner gates it with its own enable.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sb_timeout_timer.sv
// Millisecond timeout timer for USB4 sideband/LTSSM control, running directly on sb_clk.
// Optional macro SB_TIMER_PAUSE_EN adds a `pause` input that freezes the count in RUN.
module sb_timeout_timer
    import usb4_timer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = CYCLES_PER_MS_DEF,
    parameter int unsigned TMR_W         = TMR_W_DEF
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef SB_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [TMR_W-1:0] timeout_ms,
    output logic             busy,
    output logic             expired,
    output logic             ms_tick,
    output logic [TMR_W-1:0] remaining_ms
);

    tmr_state_e       state_q, state_d;
    logic [TMR_W-1:0] rem_q, rem_d;
    logic             busy_q, expired_q, expired_d, tick_q, tick_d;
    logic             pre_en, pre_clr, pre_wrap;
    logic             hold;

`ifdef SB_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    sb_ms_prescaler #(
        .CYCLES_PER_MS(CYCLES_PER_MS)
    ) u_prescaler (
        .sb_clk(sb_clk),
        .rst   (rst),
        .en    (pre_en),
        .clr   (pre_clr),
        .tick  (pre_wrap)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        expired_d = 1'b0;
        tick_d    = 1'b0;
        pre_en    = 1'b0;
        pre_clr   = 1'b0;

        unique case (state_q)
            TMR_IDLE: begin
                if (start && !stop) begin
                    rem_d   = timeout_ms;
                    pre_clr = 1'b1;
                    if (timeout_ms != '0) begin
                        state_d = TMR_RUN;
                    end else begin
                        expired_d = 1'b1;
                    end
                end
            end
            TMR_RUN: begin
                if (stop) begin
                    state_d = TMR_IDLE;
                    pre_clr = 1'b1;
                end else if (start) begin
                    // Restart swallows any expiry that was due this cycle.
                    rem_d   = timeout_ms;
                    pre_clr = 1'b1;
                    if (timeout_ms == '0) begin
                        state_d   = TMR_IDLE;
                        expired_d = 1'b1;
                    end
                end else if (!hold) begin
                    pre_en = 1'b1;
                    if (pre_wrap) begin
                        tick_d = 1'b1;
                        if (rem_q <= TMR_W'(1)) begin
                            rem_d     = '0;
                            expired_d = 1'b1;
                            state_d   = TMR_IDLE;
                        end else begin
                            rem_d = rem_q - 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = TMR_IDLE;
            end
        endcase
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= TMR_IDLE;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            busy_q    <= (state_d == TMR_RUN);
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign busy         = busy_q;
    assign expired      = expired_q;
    assign ms_tick      = tick_q;
    assign remaining_ms = rem_q;

endmodule

// File: tb/tb_sb_timeout_timer.sv
// Scoreboard bench for sb_timeout_timer; pause scenarios compile in with SB_TIMER_PAUSE_EN.
module tb_sb_timeout_timer;

    localparam int unsigned C = 4;
    localparam int unsigned W = 4;

    logic         sb_clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
`ifdef SB_TIMER_PAUSE_EN
    logic         pause = 1'b0;
`endif
    logic [W-1:0] timeout_ms = '0;
    logic         busy, expired, ms_tick;
    logic [W-1:0] remaining_ms;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic         busy;
        logic         exp;
        logic         tick;
        logic [W-1:0] rem;
    } exp_t;

    exp_t q[$];

    always #5 sb_clk = ~sb_clk;

    sb_timeout_timer #(
        .CYCLES_PER_MS(C),
        .TMR_W        (W)
    ) dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
`ifdef SB_TIMER_PAUSE_EN
        .pause       (pause),
`endif
        .timeout_ms  (timeout_ms),
        .busy        (busy),
        .expired     (expired),
        .ms_tick     (ms_tick),
        .remaining_ms(remaining_ms)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Reference model: a run is "load ms" long; elapsed counts unpaused run cycles.
    bit           m_run = 1'b0;
    int           m_load = 0;
    int           m_elapsed = 0;
    logic [W-1:0] m_rem = '0;

    initial begin
        exp_t e;
        logic pause_on;
        forever begin
            @(posedge sb_clk or negedge rst);
            e.exp  = 1'b0;
            e.tick = 1'b0;
            if (!rst) begin
                m_run     = 1'b0;
                m_rem     = '0;
                m_elapsed = 0;
                q.delete();
            end else begin
                cyc++;
`ifdef SB_TIMER_PAUSE_EN
                pause_on = pause;
`else
                pause_on = 1'b0;
`endif
                if (stop) begin
                    m_run = 1'b0;
                end else if (start) begin
                    if (timeout_ms != 0) begin
                        m_run     = 1'b1;
                        m_load    = int'(timeout_ms);
                        m_elapsed = 0;
                        m_rem     = timeout_ms;
                    end else begin
                        m_run = 1'b0;
                        m_rem = '0;
                        e.exp = 1'b1;
                    end
                end else if (m_run && !pause_on) begin
                    m_elapsed++;
                    if (m_elapsed % C == 0) begin
                        e.tick = 1'b1;
                        m_rem  = W'(m_load - m_elapsed / int'(C));
                        if (m_rem == 0) begin
                            e.exp = 1'b1;
                            m_run = 1'b0;
                        end
                    end
                end
            end
            e.busy = m_run;
            e.rem  = m_rem;
            q.push_back(e);
        end
    end

    // Monitor: registered outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge sb_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("busy", int'(busy), int'(e.busy));
                chk("expired", int'(expired), int'(e.exp));
                chk("ms_tick", int'(ms_tick), int'(e.tick));
                chk("remaining_ms", int'(remaining_ms), int'(e.rem));
            end
        end
    end

    task automatic pulse(input logic s, input logic p, input int t);
        start      = s;
        stop       = p;
        timeout_ms = W'(t);
        @(negedge sb_clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sb_clk);
    endtask

    initial begin
        idle(3);
        #2 rst = 1'b1;
        idle(2);

        // Basic 3 ms countdown.
        pulse(1'b1, 1'b0, 3);
        idle(14);

        // Stop part-way through a 5 ms run.
        pulse(1'b1, 1'b0, 5);
        idle(6);
        pulse(1'b0, 1'b1, 0);
        idle(4);

        // Restart exactly on the cycle expiry is due.
        pulse(1'b1, 1'b0, 2);
        idle(7);
        pulse(1'b1, 1'b0, 2);
        idle(10);

        // Start+stop together, then zero timeout.
        pulse(1'b1, 1'b1, 3);
        idle(2);
        pulse(1'b1, 1'b0, 0);
        idle(3);

        // Asynchronous reset mid-run while remaining_ms is 2.
        pulse(1'b1, 1'b0, 3);
        idle(5);
        @(posedge sb_clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_rem", int'(remaining_ms), 0);
        idle(2);
        #2 rst = 1'b1;
        idle(20);

`ifdef SB_TIMER_PAUSE_EN
        // Pause for 10 cycles mid-count.
        pulse(1'b1, 1'b0, 2);
        idle(2);
        pause = 1'b1;
        idle(10);
        pause = 1'b0;
        idle(15);
`endif

        for (int i = 0; i < 400; i++) begin
            int r;
            r          = int'($urandom_range(0, 99));
            start      = (r < 12);
            stop       = (r >= 10 && r < 16);
            timeout_ms = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 5));
`ifdef SB_TIMER_PAUSE_EN
            if ($urandom_range(0, 7) == 0) pause = ~pause;
`endif
            @(negedge sb_clk);
            start = 1'b0;
            stop  = 1'b0;
            idle(int'($urandom_range(0, 6)));
        end

`ifdef SB_TIMER_PAUSE_EN
        pause = 1'b0;
`endif
        idle(40);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
